// File: rtl/uart_dmem_loader_pkg.sv
// Shared types and constants for the UART data-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package loader_pkg;

  // Frame-level states of the loader.
  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  // Bit-level states of the UART receiver.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchronizer, start-bit validation, centre sampling.
// Latency: rx_valid/rx_ferr pulse one cycle after the stop-bit centre sample.
// Backpressure: none; each byte is a single-cycle pulse the consumer must take.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_o,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             valid_nxt;
  logic             ferr_nxt;
  logic [7:0]       data_nxt;

  // Bring the asynchronous line into the clock domain; rx_prev gives edge detection.
  always_ff @(posedge clk_o) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit FSM state and datapath registers.
  always_ff @(posedge clk_o) begin
    if (!reset) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      rx_valid <= valid_nxt;
      rx_ferr  <= ferr_nxt;
      rx_data  <= data_nxt;
    end
  end

  // Next-state: a start is only accepted if the line is still low half a bit later.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    data_nxt    = rx_data;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_sync ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt     = '0;
          shift_nxt   = {rx_sync, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          if (rx_sync) begin
            valid_nxt = 1'b1;
            data_nxt  = shift;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_dmem_loader.sv
// Boot loader: UART frame (LEN_LO, LEN_HI, 4*N LE bytes) -> one-cycle word writes to data memory.
// Latency: write pulse one cycle after the 4th byte of a word; DONE one cycle after the last write.
// Backpressure: none; memory accepts every pulse. Optional trailing XOR byte via LOADER_CHECKSUM_EN.
module uart_dmem_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 256
) (
  input  logic        clk_o,
  input  logic        reset,
  input  logic        uart_rx_i,
  output logic [31:0] addrS_LSU,
  output logic [31:0] store,
  output logic [3:0]  mask,
  output logic        wr_E,
  output logic        cs_E,
  output logic        Data_Memory_on,
  output logic        load_busy,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ferr;
  loader_state_t    state;
  loader_state_t    state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] n_full;
  logic [1:0]       byte_idx;
  logic             last_byte;
  logic             last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  localparam loader_state_t AFTER_LAST = CHK;
`else
  localparam loader_state_t AFTER_LAST = DONE;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_o   (clk_o),
    .reset   (reset),
    .rx      (uart_rx_i),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ferr (rx_ferr)
  );

  assign n_full    = {rx_data, len[7:0]};
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign last_word = ((words_loaded + 16'd1) == len);

  // Frame state register.
  always_ff @(posedge clk_o) begin
    if (!reset) state <= LEN_LO;
    else        state <= state_nxt;
  end

  // Frame sequencing; DONE and ERROR are terminal until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: begin
        if (rx_ferr)       state_nxt = ERROR;
        else if (rx_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (rx_ferr) begin
          state_nxt = ERROR;
        end else if (rx_valid) begin
          if (n_full == '0)                 state_nxt = AFTER_LAST;
          else if (n_full > LEN_W'(DEPTH))  state_nxt = ERROR;
          else                              state_nxt = DATA;
        end
      end
      DATA: begin
        if (rx_ferr)                     state_nxt = ERROR;
        else if (rx_valid && last_byte)  state_nxt = WRITE;
      end
      WRITE: state_nxt = last_word ? AFTER_LAST : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_ferr)       state_nxt = ERROR;
        else if (rx_valid) state_nxt = (rx_data == csum) ? DONE : ERROR;
      end
`endif
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = LEN_LO;
    endcase
  end

  // Memory port strobes and status flags are pure decodes of the state.
  always_comb begin
    wr_E           = (state == WRITE);
    cs_E           = (state != WRITE);
    mask           = (state == WRITE) ? 4'hF : 4'h0;
    Data_Memory_on = (state == DONE);
    load_err       = (state == ERROR);
    load_busy      = (state inside {LEN_HI, DATA, WRITE, CHK});
  end

  // Length capture, word assembly and write address; address/data hold between writes.
  always_ff @(posedge clk_o) begin
    if (!reset) begin
      len          <= '0;
      byte_idx     <= '0;
      store        <= '0;
      addrS_LSU    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        LEN_LO: if (rx_valid) len[7:0] <= rx_data;
        LEN_HI: if (rx_valid) len[LEN_W-1:8] <= rx_data;
        DATA: begin
          if (rx_valid) begin
            store[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx                       <= byte_idx + 2'd1;
            if (last_byte) addrS_LSU <= 32'(words_loaded);
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          byte_idx     <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over data bytes only; length bytes never reach DATA.
  always_ff @(posedge clk_o) begin
    if (!reset)                          csum <= '0;
    else if (state == DATA && rx_valid)  csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: doc/uart_dmem_loader.md
Name: uart_dmem_loader

Overview:
- Boot-time loader that sits directly upstream of the data memory write port.
- Receives a framed image over UART 8N1, assembles little-endian 32-bit words and writes word k to address k through the memory's store interface.
- After a successful load it raises Data_Memory_on, which enables the data memory for the pipeline.

Parameters:
- CLKS_PER_BIT, 868, clk_o cycles per UART bit (100 MHz / 115200); minimum 4.
- DEPTH, 256, data memory depth in words; the largest legal word count.

Ports:
- clk_o  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- uart_rx_i  in  1  serial input, idle high, asynchronous to clk_o.
- addrS_LSU  out  32  write word address.
- store  out  32  write data.
- mask  out  4  byte enables; always 4'hF during a write.
- wr_E  out  1  write enable, active high.
- cs_E  out  1  chip select, active low.
- Data_Memory_on  out  1  load complete; memory enabled.
- load_busy  out  1  high from the first length byte until DONE or ERROR.
- load_err  out  1  sticky error flag.
- words_loaded  out  16  count of words written.

Behaviour:
- Reset (reset==0 at a posedge): state=LEN_LO, addrS_LSU=0, store=0, mask=0, wr_E=0, cs_E=1, Data_Memory_on=0, load_busy=0, load_err=0, words_loaded=0. The RX sub-module is also reset.
- Reset mid-load: abort immediately; no write pulse follows; full re-load required.
- RX input: uart_rx_i passes through a 2-flop synchronizer.
- RX start detect: falling edge, then re-check at CLKS_PER_BIT/2. If the line is high there, the start is false and RX returns to idle.
- RX data sampling: 8 data bits LSB-first, each sampled at bit centre.
- RX stop bit: sampled at centre. 1 gives a one-cycle rx_valid with rx_data. 0 gives a one-cycle rx_ferr and no rx_valid.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4*N data bytes, each word least-significant byte first.
- FSM LEN_LO: on rx_valid, latch N[7:0], set load_busy=1, go to LEN_HI.
- FSM LEN_HI: on rx_valid, latch N[15:8].
  - N==0 → DONE.
  - N>DEPTH → ERROR.
  - Otherwise → DATA.
- FSM DATA: on rx_valid, place the byte in store[8*byte_idx +: 8] and increment the 2-bit byte_idx. On the 4th byte → WRITE.
- FSM WRITE: exactly one cycle with cs_E=0, wr_E=1, mask=4'hF, addrS_LSU=words_loaded, store holding the word. The memory samples on the following negedge.
- WRITE next cycle: words_loaded+1 and byte_idx=0. If words_loaded+1==N → DONE (or CHK with the optional feature), else → DATA.
- Bytes arriving during WRITE: cannot be lost, since a byte takes ≥10*CLKS_PER_BIT cycles.
- FSM DONE: Data_Memory_on=1, load_busy=0. Stays here until reset; further RX bytes are ignored.
- FSM ERROR: load_err=1, load_busy=0, Data_Memory_on=0. Stays here until reset.
- rx_ferr in any of LEN_LO..DATA: → ERROR.
- Outside WRITE: cs_E=1, wr_E=0, mask=0. addrS_LSU and store hold their last values.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: after the last data word the FSM enters CHK and waits for one byte. It compares that byte to the running XOR of all 4*N data bytes (LEN bytes excluded).
  - Match → DONE.
  - Mismatch or rx_ferr → ERROR.
  - N==0 also passes through CHK, expecting 8'h00.
- Memory writes still occur before the check. Only Data_Memory_on is withheld on mismatch.
- Undefined: no CHK state, no XOR register; the FSM goes straight to DONE.

Decomposition:
- Package loader_pkg:
  - typedef enum loader_state_t {LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR}.
  - Constant BYTES_PER_WORD=4.
  - Constant LEN_W=16.
- Sub-module uart_rx_byte (params CLKS_PER_BIT):
  - Inputs: clk_o, reset, rx.
  - Outputs: rx_valid, rx_data[7:0], rx_ferr.
  - Contains the synchronizer, baud counter and bit FSM.
- The top holds the frame FSM, word assembly and memory-port drive.

Test Plan (CLKS_PER_BIT=8):
- Normal load: send 02 00, then EF BE AD DE, 04 03 02 01 → write pulses store=32'hDEADBEEF@addr0 and 32'h01020304@addr1, mask=F each for exactly 1 cycle; then Data_Memory_on=1, words_loaded=2, load_err=0.
- Zero length: send 00 00 → DONE with no write pulse; Data_Memory_on=1 (with LOADER_CHECKSUM_EN: only after an additional 00).
- Oversize: send 01 01 (N=257) → load_err=1, no writes, Data_Memory_on stays 0.
- Framing error: second data byte sent with stop bit=0 → ERROR, no write pulse. A 2-cycle glitch low on idle uart_rx_i produces no rx_valid.
- Reset after 5 of 8 data bytes of N=2: exactly one write done; after reset all outputs are at reset values. A fresh 01 00 11 22 33 44 then writes 32'h44332211@0.
- LOADER_CHECKSUM_EN: N=1, data 01 02 03 04, checksum 04 → DONE. Checksum 05 → ERROR, with the word still written.
